mult_div_unit: RTL and testbench

- Multicycle signed multiply/divide datapath block for the MIPS-subset processor.
- Sits directly downstream of the control unit: consumes its 2-bit mult_div command and the A/B register values.
- Produces the HI/LO registers read by MFHI/MFLO, plus the div0 exception flag fed back to the control unit.
- The control unit polls done/div0 to leave its MULT_CALC / DIV_CALC wait states.

---
 rtl/mult_div_if.sv | 24 ++
 rtl/mult_div_unit.sv | 146 ++++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Command/result bundle between the control unit and the multiply/divide unit.
// The control unit is the master; the arithmetic unit is the slave.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       mult_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0;

    modport master (
        output mult_div, a, b,
        input  hi, lo, busy, done, div0
    );

    modport slave (
        input  mult_div, a, b,
        output hi, lo, busy, done, div0
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring on magnitudes)
// producing the HI/LO registers, with done and divide-by-zero pulses.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic      clock,
    input  logic      reset,
    mult_div_if.slave bus
);
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t           state_reg;
    logic             op_div_reg;
    logic [WIDTH:0]   acc_hi_reg;
    logic [WIDTH-1:0] acc_lo_reg;
    logic             q_prev_reg;
    logic [WIDTH-1:0] m_reg;
    logic             neg_quo_reg;
    logic             neg_rem_reg;
    logic [CW-1:0]    step_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             div0_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   booth_addend;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] quo_signed;
    logic [WIDTH-1:0] rem_signed;
    logic             last_step;

    always_comb begin
        a_mag        = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_mag        = bus.b[WIDTH-1] ? -bus.b : bus.b;
        // Booth add/sub is done one bit wider so subtracting the most negative
        // multiplicand cannot overflow before the arithmetic shift.
        booth_addend = {m_reg[WIDTH-1], m_reg};
        booth_sum    = acc_hi_reg;
        case ({acc_lo_reg[0], q_prev_reg})
            2'b01:   booth_sum = acc_hi_reg + booth_addend;
            2'b10:   booth_sum = acc_hi_reg - booth_addend;
            default: booth_sum = acc_hi_reg;
        endcase
        div_shift    = {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]};
        div_diff     = div_shift - {1'b0, m_reg};
        quo_signed   = neg_quo_reg ? -acc_lo_reg : acc_lo_reg;
        rem_signed   = neg_rem_reg ? -acc_hi_reg[WIDTH-1:0] : acc_hi_reg[WIDTH-1:0];
        last_step    = (step_reg == CW'(STEPS - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            op_div_reg  <= 1'b0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            q_prev_reg  <= 1'b0;
            m_reg       <= '0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            step_reg    <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            div0_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            div0_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    step_reg <= '0;
                    if (bus.mult_div == 2'b01) begin
                        state_reg  <= MULT;
                        op_div_reg <= 1'b0;
                        busy_reg   <= 1'b1;
                        acc_hi_reg <= '0;
                        acc_lo_reg <= bus.b;
                        q_prev_reg <= 1'b0;
                        m_reg      <= bus.a;
                    end else if (bus.mult_div == 2'b10) begin
                        if (bus.b == '0) begin
                            div0_reg <= 1'b1;
                        end else begin
                            state_reg   <= DIV;
                            op_div_reg  <= 1'b1;
                            busy_reg    <= 1'b1;
                            acc_hi_reg  <= '0;
                            acc_lo_reg  <= a_mag;
                            q_prev_reg  <= 1'b0;
                            m_reg       <= b_mag;
                            neg_quo_reg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            neg_rem_reg <= bus.a[WIDTH-1];
                        end
                    end
                end
                MULT: begin
                    acc_hi_reg <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    acc_lo_reg <= {booth_sum[0], acc_lo_reg[WIDTH-1:1]};
                    q_prev_reg <= acc_lo_reg[0];
                    step_reg   <= last_step ? '0 : step_reg + 1'b1;
                    if (last_step) state_reg <= FINISH;
                end
                DIV: begin
                    // Restore by simply keeping the shifted value when the trial goes negative.
                    if (!div_diff[WIDTH]) begin
                        acc_hi_reg <= div_diff;
                        acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_reg <= div_shift;
                        acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b0};
                    end
                    step_reg <= last_step ? '0 : step_reg + 1'b1;
                    if (last_step) state_reg <= FINISH;
                end
                FINISH: begin
                    if (op_div_reg) begin
                        hi_reg <= rem_signed;
                        lo_reg <= quo_signed;
                    end else begin
                        hi_reg <= acc_hi_reg[WIDTH-1:0];
                        lo_reg <= acc_lo_reg;
                    end
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.div0 = div0_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed results, div-by-zero,
// ignored commands while busy and reset abort.
module tb_mult_div_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .STEPS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Drive a command so it is sampled on the next rising edge (edge 1), then clear it.
    task automatic do_start(input logic [1:0] cmd, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clock);
        bus.mult_div = cmd;
        bus.a = av;
        bus.b = bv;
        @(posedge clock);
        #1;
        bus.mult_div = 2'b00;
    endtask

    // Wait (bounded) for done; returns the edge index where done appeared.
    task automatic wait_done(input int start, output int edge_n, output bit busy_gap);
        edge_n = start;
        busy_gap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            edge_n++;
            if (bus.done) break;
            if (!bus.busy) busy_gap = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.mult_div = 2'b00;
        bus.a = '0;
        bus.b = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests++; if (bus.hi !== 32'h0) begin fails++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        tests++; if (bus.lo !== 32'h0) begin fails++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        tests++; if (bus.div0 !== 1'b0) begin fails++; $display("FAIL reset_div0 got=%b exp=0", bus.div0); end
        @(negedge clock);
        reset = 1'b0;
        $display("[TB] reset released");
    endtask

    task automatic test_mult_neg();
        int e;
        bit gap;
        do_start(2'b01, 32'd7, 32'hFFFFFFFD);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mneg_busy_e1 got=%b exp=1", bus.busy); end
        wait_done(1, e, gap);
        tests++; if (e != 34) begin fails++; $display("FAIL mneg_latency got=%0d exp=34", e); end
        tests++; if (gap !== 1'b0) begin fails++; $display("FAIL mneg_busy_gap got=%b exp=0", gap); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mneg_busy_e34 got=%b exp=0", bus.busy); end
        tests++; if (bus.hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mneg_hi got=%h exp=ffffffff", bus.hi); end
        tests++; if (bus.lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mneg_lo got=%h exp=ffffffeb", bus.lo); end
        $display("[TB] MULT 7 * -3 -> hi=%h lo=%h edge=%0d", bus.hi, bus.lo, e);
        @(posedge clock);
        #1;
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL mneg_done_width got=%b exp=0", bus.done); end
        tests++; if (bus.lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mneg_lo_hold got=%h exp=ffffffeb", bus.lo); end
    endtask

    task automatic test_mult_min();
        int e;
        bit gap;
        do_start(2'b01, 32'h80000000, 32'h80000000);
        wait_done(1, e, gap);
        tests++; if (e != 34) begin fails++; $display("FAIL mmin_latency got=%0d exp=34", e); end
        tests++; if (bus.hi !== 32'h40000000) begin fails++; $display("FAIL mmin_hi got=%h exp=40000000", bus.hi); end
        tests++; if (bus.lo !== 32'h00000000) begin fails++; $display("FAIL mmin_lo got=%h exp=00000000", bus.lo); end
        $display("[TB] MULT 0x80000000 * 0x80000000 -> hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    // Second DIV is issued in the cycle done is high, so it must be accepted.
    task automatic test_back_to_back();
        int e;
        bit gap;
        do_start(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_done(1, e, gap);
        tests++; if (e != 34) begin fails++; $display("FAIL dneg_latency got=%0d exp=34", e); end
        tests++; if (bus.lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL dneg_lo got=%h exp=fffffffd", bus.lo); end
        tests++; if (bus.hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL dneg_hi got=%h exp=ffffffff", bus.hi); end
        $display("[TB] DIV -7 / 2 -> hi=%h lo=%h", bus.hi, bus.lo);
        do_start(2'b10, 32'd100, 32'd7);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
        wait_done(1, e, gap);
        tests++; if (e != 34) begin fails++; $display("FAIL b2b_latency got=%0d exp=34", e); end
        tests++; if (bus.lo !== 32'd14) begin fails++; $display("FAIL b2b_lo got=%h exp=0000000e", bus.lo); end
        tests++; if (bus.hi !== 32'd2) begin fails++; $display("FAIL b2b_hi got=%h exp=00000002", bus.hi); end
        $display("[TB] DIV 100 / 7 -> hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    task automatic test_div_special();
        int e;
        bit gap;
        do_start(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done(1, e, gap);
        tests++; if (bus.lo !== 32'h80000000) begin fails++; $display("FAIL dmin_lo got=%h exp=80000000", bus.lo); end
        tests++; if (bus.hi !== 32'h00000000) begin fails++; $display("FAIL dmin_hi got=%h exp=00000000", bus.hi); end
        tests++; if (bus.div0 !== 1'b0) begin fails++; $display("FAIL dmin_div0 got=%b exp=0", bus.div0); end
        $display("[TB] DIV 0x80000000 / -1 -> hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    task automatic test_div0();
        int e;
        bit gap;
        bit seen_busy;
        bit seen_done;
        do_start(2'b10, 32'h2211, 32'h100);
        wait_done(1, e, gap);
        tests++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            fails++; $display("FAIL div0_setup got=%h/%h exp=00000011/00000022", bus.hi, bus.lo);
        end
        do_start(2'b10, 32'd5, 32'd0);
        tests++; if (bus.div0 !== 1'b1) begin fails++; $display("FAIL div0_pulse got=%b exp=1", bus.div0); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL div0_busy got=%b exp=0", bus.busy); end
        seen_busy = 1'b0;
        seen_done = 1'b0;
        @(posedge clock);
        #1;
        tests++; if (bus.div0 !== 1'b0) begin fails++; $display("FAIL div0_width got=%b exp=0", bus.div0); end
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) seen_busy = 1'b1;
            if (bus.done) seen_done = 1'b1;
            @(posedge clock);
            #1;
        end
        tests++; if (seen_busy !== 1'b0) begin fails++; $display("FAIL div0_no_busy got=%b exp=0", seen_busy); end
        tests++; if (seen_done !== 1'b0) begin fails++; $display("FAIL div0_no_done got=%b exp=0", seen_done); end
        tests++; if (bus.hi !== 32'h11) begin fails++; $display("FAIL div0_hi_hold got=%h exp=00000011", bus.hi); end
        tests++; if (bus.lo !== 32'h22) begin fails++; $display("FAIL div0_lo_hold got=%h exp=00000022", bus.lo); end
        $display("[TB] DIV 5 / 0 -> div0 pulse, hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    task automatic test_ignore_cmd();
        int e;
        bit gap;
        do_start(2'b01, 32'd3, 32'd4);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        bus.mult_div = 2'b10;
        bus.a = 32'd99;
        bus.b = 32'd0;
        @(posedge clock);
        #1;
        bus.mult_div = 2'b00;
        tests++; if (bus.div0 !== 1'b0) begin fails++; $display("FAIL ign_div0 got=%b exp=0", bus.div0); end
        wait_done(5, e, gap);
        tests++; if (e != 34) begin fails++; $display("FAIL ign_latency got=%0d exp=34", e); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL ign_hi got=%h exp=00000000", bus.hi); end
        tests++; if (bus.lo !== 32'd12) begin fails++; $display("FAIL ign_lo got=%h exp=0000000c", bus.lo); end
        $display("[TB] MULT 3 * 4 with DIV at edge 5 -> hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    task automatic test_reset_abort();
        int e;
        bit gap;
        bit seen_done;
        do_start(2'b10, 32'd100, 32'd7);
        repeat (8) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL abort_hi got=%h exp=00000000", bus.hi); end
        tests++; if (bus.lo !== 32'd0) begin fails++; $display("FAIL abort_lo got=%h exp=00000000", bus.lo); end
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.div0) seen_done = 1'b1;
        end
        tests++; if (seen_done !== 1'b0) begin fails++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
        do_start(2'b01, 32'd2, 32'd2);
        wait_done(1, e, gap);
        tests++; if (e != 34) begin fails++; $display("FAIL abort_mult_latency got=%0d exp=34", e); end
        tests++; if (bus.lo !== 32'd4) begin fails++; $display("FAIL abort_mult_lo got=%h exp=00000004", bus.lo); end
        tests++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL abort_mult_hi got=%h exp=00000000", bus.hi); end
        $display("[TB] DIV aborted by reset, then MULT 2 * 2 -> hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    initial begin
        test_reset();
        test_mult_neg();
        test_mult_min();
        test_back_to_back();
        test_div_special();
        test_div0();
        test_ignore_cmd();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
